// File: rtl/time_field_adjuster.sv
`timescale 1ns/1ps
// time_field_adjuster
// Edits a stored hours:minutes value one field at a time from step pulses
// produced by the press detector. It is used for both clock-time and
// alarm-time setting, and it outputs binary and BCD copies for the display.
//
// Ports
//   clk_100Hz            system clock
//   rst_n                asynchronous active-low reset
//   edit_en              editing allowed while high
//   field_sel            0 = edit minutes, 1 = edit hours
//   signal               step request (a rising edge is one step)
//   increment_positivity 0 = increment, 1 = decrement
//   load                 load load_hours/load_minutes on the next edge (clamped)
//   load_hours/minutes   values to load
//   hours/minutes        current value, binary
//   hours_bcd/minutes_bcd current value as {tens, ones}
//   changed              1-cycle pulse when either field changes
//   wrapped              1-cycle pulse when a step wraps a field
module time_field_adjuster #(
  parameter int MAX_HOURS   = 24,
  parameter int MAX_MINUTES = 60
) (
  input  logic       clk_100Hz,
  input  logic       rst_n,
  input  logic       edit_en,
  input  logic       field_sel,
  input  logic       signal,
  input  logic       increment_positivity,
  input  logic       load,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic       changed,
  output logic       wrapped
);

  localparam logic [4:0] HR_TOP  = 5'(MAX_HOURS - 1);
  localparam logic [5:0] MIN_TOP = 6'(MAX_MINUTES - 1);

  typedef enum logic [1:0] {IDLE, EDIT_MIN, EDIT_HR} state_t;

  state_t     state_reg;
  logic       signal_reg;
  logic       step_reg;
  logic       dec_reg;
  logic [4:0] hours_reg, hours_next;
  logic [5:0] minutes_reg, minutes_next;
  logic [7:0] hours_bcd_reg, minutes_bcd_reg;
  logic       changed_reg, wrapped_reg, wrapped_next;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

  // Next field values. Load wins over a pending step; the step is lost.
  always_comb begin
    hours_next   = hours_reg;
    minutes_next = minutes_reg;
    wrapped_next = 1'b0;
    if (load) begin
      hours_next   = (load_hours   > HR_TOP)  ? HR_TOP  : load_hours;
      minutes_next = (load_minutes > MIN_TOP) ? MIN_TOP : load_minutes;
    end else if (step_reg) begin
      case (state_reg)
        EDIT_MIN: begin
          if (!dec_reg) begin
            if (minutes_reg == MIN_TOP) begin
              minutes_next = 6'd0;
              wrapped_next = 1'b1;
            end else begin
              minutes_next = minutes_reg + 6'd1;
            end
          end else begin
            if (minutes_reg == 6'd0) begin
              minutes_next = MIN_TOP;
              wrapped_next = 1'b1;
            end else begin
              minutes_next = minutes_reg - 6'd1;
            end
          end
        end
        EDIT_HR: begin
          if (!dec_reg) begin
            if (hours_reg == HR_TOP) begin
              hours_next   = 5'd0;
              wrapped_next = 1'b1;
            end else begin
              hours_next = hours_reg + 5'd1;
            end
          end else begin
            if (hours_reg == 5'd0) begin
              hours_next   = HR_TOP;
              wrapped_next = 1'b1;
            end else begin
              hours_next = hours_reg - 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The step pulse and the state are registered on the same edge, so a
  // step is applied according to edit_en/field_sel seen in its edge cycle.
  // A rising edge that coincides with a load is discarded here, so the
  // step is never applied on top of the freshly loaded value.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      signal_reg      <= 1'b0;
      step_reg        <= 1'b0;
      dec_reg         <= 1'b0;
      hours_reg       <= 5'd0;
      minutes_reg     <= 6'd0;
      hours_bcd_reg   <= 8'h00;
      minutes_bcd_reg <= 8'h00;
      changed_reg     <= 1'b0;
      wrapped_reg     <= 1'b0;
    end else begin
      signal_reg <= signal;
      step_reg   <= signal & ~signal_reg & ~load;
      dec_reg    <= increment_positivity;
      if (!edit_en)       state_reg <= IDLE;
      else if (field_sel) state_reg <= EDIT_HR;
      else                state_reg <= EDIT_MIN;
      hours_reg       <= hours_next;
      minutes_reg     <= minutes_next;
      hours_bcd_reg   <= to_bcd({2'b00, hours_next});
      minutes_bcd_reg <= to_bcd({1'b0, minutes_next});
      changed_reg     <= (hours_next != hours_reg) || (minutes_next != minutes_reg);
      wrapped_reg     <= wrapped_next;
    end
  end

  assign hours       = hours_reg;
  assign minutes     = minutes_reg;
  assign hours_bcd   = hours_bcd_reg;
  assign minutes_bcd = minutes_bcd_reg;
  assign changed     = changed_reg;
  assign wrapped     = wrapped_reg;

endmodule

// File: tb/tb_time_field_adjuster.sv
`timescale 1ns/1ps
module tb_time_field_adjuster;

  localparam int MH = 24;
  localparam int MM = 60;

  logic       clk_100Hz = 1'b0;
  logic       rst_n = 1'b0;
  logic       edit_en = 1'b0;
  logic       field_sel = 1'b0;
  logic       signal = 1'b0;
  logic       increment_positivity = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_hours = '0;
  logic [5:0] load_minutes = '0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [7:0] hours_bcd, minutes_bcd;
  logic       changed, wrapped;

  time_field_adjuster #(.MAX_HOURS(MH), .MAX_MINUTES(MM)) dut (
    .clk_100Hz(clk_100Hz), .rst_n(rst_n), .edit_en(edit_en),
    .field_sel(field_sel), .signal(signal),
    .increment_positivity(increment_positivity), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes),
    .hours(hours), .minutes(minutes), .hours_bcd(hours_bcd),
    .minutes_bcd(minutes_bcd), .changed(changed), .wrapped(wrapped)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  typedef struct {
    int h;
    int m;
    bit w;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int exp_h = 0;
  int exp_m = 0;

  function automatic void check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endfunction

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  // Monitor: every changed pulse must match the oldest expected update.
  always @(negedge clk_100Hz) begin
    if (rst_n) begin
      if (changed) begin
        if (q.size() == 0) begin
          check("unexpected_changed", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("hours", int'(hours), e.h);
          check("minutes", int'(minutes), e.m);
          check("hours_bcd", int'(hours_bcd), bcd(e.h));
          check("minutes_bcd", int'(minutes_bcd), bcd(e.m));
          check("wrapped", int'(wrapped), int'(e.w));
          $display("[TB] update %02d:%02d wrapped=%0d", e.h, e.m, e.w);
        end
      end else if (wrapped) begin
        check("wrapped_without_changed", 1, 0);
      end
    end
  end

  // One step transaction. The reference model is applied at the rising edge.
  task automatic do_step(input bit en, input bit fsel, input bit dec, input int hold);
    bit w;
    edit_en = en; field_sel = fsel; increment_positivity = dec; signal = 1'b0;
    repeat (2) @(posedge clk_100Hz); #1;
    if (en) begin
      if (fsel) begin
        w = dec ? (exp_h == 0) : (exp_h == MH - 1);
        exp_h = dec ? (exp_h + MH - 1) % MH : (exp_h + 1) % MH;
      end else begin
        w = dec ? (exp_m == 0) : (exp_m == MM - 1);
        exp_m = dec ? (exp_m + MM - 1) % MM : (exp_m + 1) % MM;
      end
      q.push_back('{exp_h, exp_m, w});
    end
    signal = 1'b1;
    repeat (hold) @(posedge clk_100Hz); #1;
    signal = 1'b0;
    repeat (3) @(posedge clk_100Hz); #1;
  endtask

  // Load transaction, optionally with a step edge in the same cycle.
  task automatic do_load(input int lh, input int lm, input bit with_step);
    int nh, nm;
    signal = 1'b0;
    if (with_step) begin
      edit_en = 1'b1; field_sel = 1'b0; increment_positivity = 1'b0;
      repeat (2) @(posedge clk_100Hz); #1;
    end
    nh = (lh >= MH) ? MH - 1 : lh;
    nm = (lm >= MM) ? MM - 1 : lm;
    if (nh != exp_h || nm != exp_m) q.push_back('{nh, nm, 1'b0});
    exp_h = nh; exp_m = nm;
    load = 1'b1; load_hours = 5'(lh); load_minutes = 6'(lm);
    if (with_step) signal = 1'b1;
    @(posedge clk_100Hz); #1;
    load = 1'b0;
    @(posedge clk_100Hz); #1;
    signal = 1'b0;
    repeat (3) @(posedge clk_100Hz); #1;
  endtask

  task automatic check_now(input string tag);
    check({tag, "_hours"}, int'(hours), exp_h);
    check({tag, "_minutes"}, int'(minutes), exp_m);
  endtask

  initial begin
    #23;
    check("rst_hours", int'(hours), 0);
    check("rst_minutes", int'(minutes), 0);
    check("rst_bcd", int'({hours_bcd, minutes_bcd}), 0);
    check("rst_pulses", int'({changed, wrapped}), 0);
    #9 rst_n = 1'b1;
    @(posedge clk_100Hz); #1;

    // Three separate increments of minutes.
    repeat (3) do_step(1, 0, 0, 1);
    check_now("three_steps");
    check("three_steps_bcd", int'(minutes_bcd), 8'h03);

    // 23:59 wraps per field, no carry.
    do_load(23, 59, 0);
    do_step(1, 0, 0, 1);
    check_now("min_wrap");
    do_step(1, 1, 0, 1);
    check_now("hr_wrap");

    // Decrement wraps from 00:00.
    do_step(1, 1, 1, 2);
    check("hr_dec_bcd", int'(hours_bcd), 8'h23);
    do_step(1, 0, 1, 1);
    check("min_dec_bcd", int'(minutes_bcd), 8'h59);

    // Held-high signal gives one step; idle pulses are discarded.
    do_step(1, 0, 0, 50);
    check_now("held");
    repeat (5) do_step(0, 0, 0, 1);
    check_now("idle");

    // Clamped load coincident with a step edge: the step is dropped.
    do_load(30, 63, 1);
    check_now("clamp_load");
    do_load(23, 59, 0);  // identical values, no changed pulse expected

    // Randomized mix.
    for (int i = 0; i < 200; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 8)
        do_step(($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom),
                $urandom_range(1, 4));
      else
        do_load($urandom_range(0, 31), $urandom_range(0, 63), 1'($urandom));
    end
    check_now("random_end");

    // Asynchronous reset mid-edit at 12:34.
    do_load(12, 34, 0);
    edit_en = 1'b1; field_sel = 1'b0;
    @(posedge clk_100Hz); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_hours", int'(hours), 0);
    check("async_rst_minutes", int'(minutes), 0);
    check("async_rst_bcd", int'({hours_bcd, minutes_bcd}), 0);
    check("async_rst_pulses", int'({changed, wrapped}), 0);
    #1000;
    rst_n = 1'b1;
    exp_h = 0; exp_m = 0;
    do_step(1, 0, 0, 1);
    check_now("post_rst");

    check("queue_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/time_field_adjuster.md
Name: time_field_adjuster

Overview:
- Consumer of the press-detector step interface: turns step pulses (`signal`) and direction (`increment_positivity`) into edits of a stored hours:minutes value.
- Used for both clock-time setting and alarm-time setting.
- Edits one field at a time, selected by `field_sel`, while `edit_en` is high. Each field wraps independently.
- Provides binary and BCD outputs for the display path.

Parameters:
- MAX_HOURS, 24, hour modulus; hours range 0..MAX_HOURS-1
- MAX_MINUTES, 60, minute modulus; minutes range 0..MAX_MINUTES-1

Ports:
- clk_100Hz  input  1  system clock, 100 Hz
- rst_n  input  1  asynchronous active-low reset
- edit_en  input  1  editing allowed while high
- field_sel  input  1  0 = edit minutes, 1 = edit hours
- signal  input  1  step request from the press detector
- increment_positivity  input  1  0 = increment, 1 = decrement
- load  input  1  synchronous load of load_hours/load_minutes
- load_hours  input  5  hours value to load
- load_minutes  input  6  minutes value to load
- hours  output  5  current hours, binary
- minutes  output  6  current minutes, binary
- hours_bcd  output  8  hours as two BCD digits {tens, ones}
- minutes_bcd  output  8  minutes as two BCD digits {tens, ones}
- changed  output  1  1-cycle pulse whenever hours or minutes changes
- wrapped  output  1  1-cycle pulse when a step wraps a field

Behaviour:
- Reset (asynchronous, rst_n=0):
  - hours=0, minutes=0, hours_bcd=8'h00, minutes_bcd=8'h00
  - changed=0, wrapped=0
  - state=IDLE, signal edge register=0
- Step detection:
  - signal is registered every cycle.
  - A step occurs on a cycle where signal=1 and the registered previous value=0 (rising edge).
  - A held-high signal produces exactly one step.
  - Direction is increment_positivity sampled in the same cycle as the edge.
- State machine, three states, re-evaluated every cycle:
  - IDLE: edit_en=0; all steps ignored.
  - EDIT_MIN: edit_en=1 and field_sel=0.
  - EDIT_HR: edit_en=1 and field_sel=1.
  - The state register updates every cycle. A step is applied according to the state held in that cycle, so a field_sel change takes effect one cycle later.
- Step arithmetic (applied to the selected field on the clock edge following detection):
  - Increment: value==MAX-1 gives 0 with wrapped=1; otherwise value+1.
  - Decrement: value==0 gives MAX-1 with wrapped=1; otherwise value-1.
  - Fields are independent: a minute wrap never carries into or borrows from hours.
- Load:
  - load=1 writes both fields on the next clock edge.
  - Out-of-range inputs clamp: load_hours>=MAX_HOURS gives MAX_HOURS-1; load_minutes>=MAX_MINUTES gives MAX_MINUTES-1.
  - Load has priority over a simultaneous step; the step is dropped, not deferred.
  - Load works in any state, including IDLE.
- changed:
  - Asserted for exactly one cycle, coincident with the new hours/minutes values, whenever a step or load alters either value.
  - Not asserted if a load writes identical values.
- wrapped:
  - Asserted for exactly one cycle, coincident with the wrapped value.
  - Never asserted by load.
- BCD outputs:
  - Registered, updated on the same edge as the binary values, so they are always consistent with hours/minutes.
  - tens = value/10, ones = value%10, computed from the next-state value.
- Latency: signal rising edge at input in cycle N; new value visible after the clock edge ending cycle N+1 (the input register plus the update register).
- Steps arriving while edit_en=0 are discarded, not queued.
- The signal edge register still tracks during IDLE, so a press held through edit_en rising produces no step.
- Reset mid-operation: outputs return to reset values immediately, independent of the clock.

Test Plan:
- Reset, edit_en=1, field_sel=0, 3 separate signal pulses with inc=0 -> minutes=3, minutes_bcd=8'h03, changed pulses 3 times, wrapped never.
- load 23:59, then EDIT_MIN step inc=0 -> minutes=0, hours=23 (no carry), wrapped=1 for one cycle; then EDIT_HR step inc=0 -> hours=0, hours_bcd=8'h00, wrapped=1.
- From 00:00 in EDIT_HR, step inc=1 -> hours=23, hours_bcd=8'h23; EDIT_MIN step inc=1 -> minutes=59, minutes_bcd=8'h59.
- signal held high 50 cycles in EDIT_MIN -> exactly one increment; edit_en=0 with 5 pulses -> values unchanged, changed=0.
- load=1 with load_hours=30, load_minutes=63 in the same cycle as a step -> 23:59, step dropped, changed=1 once, wrapped=0.
- rst_n low for 1 µs asynchronously mid-edit at 12:34 -> immediately 00:00, BCD 00/00, changed=0, wrapped=0.
